// File: rtl/puf_cro_ctrl.sv
// puf_cro_ctrl: measurement sequencer for a ring-oscillator PUF cell pair.
// Optional build macro PUF_CRO_CTRL_VOTE_EN: three passes per request with a
// majority vote on the response bit. Without it, a single pass is run.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; challenge and counts held
// SETTLE  | challenge applied, oscillators off, path settling
// MEASURE | oscillators enabled, edges counted
// DRAIN   | oscillators off, edges still in the synchronizers counted
// COMPARE | counts compared, response registered
// DONE    | resp_valid pulse, busy low
module puf_cro_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int WINDOW     = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       challenge,
    output logic             busy,
    output logic [5:0]       cro_challenge,
    output logic             cro_en,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             resp_valid,
    output logic             resp,
    output logic             tie,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETTLE  = 3'd1;
    localparam logic [2:0] MEASURE = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] COMPARE = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int TMAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
    localparam int TW   = $clog2(TMAX + 1) + 1;
    localparam logic [TW-1:0]    T_SETTLE = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]    T_WIN    = TW'(WINDOW - 1);
    localparam logic [TW-1:0]    T_DRAIN  = TW'(2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       sync_a_q, sync_b_q;
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
    logic [5:0]       chal_q;
    logic             busy_q, cro_en_q, resp_valid_q, resp_q, tie_q;
    logic             edge_a, edge_b, counting, pass_start, accept;
    logic             pass_resp, pass_tie, last_pass;

`ifdef PUF_CRO_CTRL_VOTE_EN
    logic [1:0] pass_q;
    logic [1:0] votes_q;
    logic       tie_acc_q;
    assign last_pass = (pass_q == 2'd2);
`else
    assign last_pass = 1'b1;
`endif

    // bit 1 is the synchronized level, bit 2 the previous synchronized level
    assign edge_a     = sync_a_q[1] & ~sync_a_q[2];
    assign edge_b     = sync_b_q[1] & ~sync_b_q[2];
    assign counting   = (state_q == MEASURE) || (state_q == DRAIN);
    assign accept     = (state_q == IDLE) && start;
    assign pass_start = (state_d == SETTLE) && (state_q != SETTLE);
    assign pass_resp  = (cnt_a_q > cnt_b_q);
    assign pass_tie   = (cnt_a_q == cnt_b_q);

    // Next-state and down-counter timer; each timed state exits at terminal count 0
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    timer_d = T_SETTLE;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = MEASURE;
                    timer_d = T_WIN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            MEASURE: begin
                if (timer_q == '0) begin
                    state_d = DRAIN;
                    timer_d = T_DRAIN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DRAIN: begin
                if (timer_q == '0) state_d = COMPARE;
                else               timer_d = timer_q - 1'b1;
            end
            COMPARE: begin
                if (last_pass) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    timer_d = T_SETTLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, timer and registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            cro_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            chal_q       <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            busy_q       <= (state_d != IDLE) && (state_d != DONE);
            cro_en_q     <= (state_d == MEASURE);
            resp_valid_q <= (state_d == DONE);
            if (accept) chal_q <= challenge;
        end
    end

    // Two-flop synchronizers plus an edge-detect flop per oscillator
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[1:0], ro_a};
            sync_b_q <= {sync_b_q[1:0], ro_b};
        end
    end

    // Saturating edge counters, cleared at the start of every pass
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else if (pass_start) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else if (counting) begin
            if (edge_a && (cnt_a_q != CNT_MAX)) cnt_a_q <= cnt_a_q + 1'b1;
            if (edge_b && (cnt_b_q != CNT_MAX)) cnt_b_q <= cnt_b_q + 1'b1;
        end
    end

`ifdef PUF_CRO_CTRL_VOTE_EN
    // Per-pass votes; the final pass resolves the majority and the any-tie flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q    <= '0;
            votes_q   <= '0;
            tie_acc_q <= 1'b0;
            resp_q    <= 1'b0;
            tie_q     <= 1'b0;
        end else if (accept) begin
            pass_q    <= '0;
            tie_acc_q <= 1'b0;
        end else if (state_q == COMPARE) begin
            if (last_pass) begin
                resp_q <= (votes_q[0] & votes_q[1]) | (votes_q[0] & pass_resp) |
                          (votes_q[1] & pass_resp);
                tie_q  <= tie_acc_q | pass_tie;
            end else begin
                votes_q[pass_q[0]] <= pass_resp;
                tie_acc_q          <= tie_acc_q | pass_tie;
                pass_q             <= pass_q + 2'd1;
            end
        end
    end
`else
    // Single-pass response
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= 1'b0;
            tie_q  <= 1'b0;
        end else if (state_q == COMPARE) begin
            resp_q <= pass_resp;
            tie_q  <= pass_tie;
        end
    end
`endif

    assign busy          = busy_q;
    assign cro_challenge = chal_q;
    assign cro_en        = cro_en_q;
    assign resp_valid    = resp_valid_q;
    assign resp          = resp_q;
    assign tie           = tie_q;
    assign cnt_a         = cnt_a_q;
    assign cnt_b         = cnt_b_q;

endmodule

// File: tb/tb_puf_cro_ctrl.sv
// Bench for puf_cro_ctrl: oscillator stimulus with random phase/periods, a
// window-based edge-count model and directed boundary cases.
module tb_puf_cro_ctrl;

    localparam int S   = 4;
    localparam int W   = 64;
    localparam int CW  = 8;
    localparam int WS  = 256;
    localparam int CWS = 3;
`ifdef PUF_CRO_CTRL_VOTE_EN
    localparam int NP = 3;
`else
    localparam int NP = 1;
`endif
    localparam int PASS = S + W + 4;
    localparam int LAT  = NP * PASS + 1;
    localparam int LATS = NP * (S + WS + 4) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           start_s = 1'b0;
    logic [5:0]     challenge = '0;
    logic           ro_a = 1'b0;
    logic           ro_b = 1'b0;
    logic           busy, cro_en, resp_valid, resp, tie;
    logic [5:0]     cro_challenge;
    logic [CW-1:0]  cnt_a, cnt_b;
    logic           busy_s, cro_en_s, resp_valid_s, resp_s, tie_s;
    logic [5:0]     cro_challenge_s;
    logic [CWS-1:0] cnt_a_s, cnt_b_s;

    puf_cro_ctrl #(.SETTLE_CYC(S), .WINDOW(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .busy(busy), .cro_challenge(cro_challenge), .cro_en(cro_en),
        .ro_a(ro_a), .ro_b(ro_b), .resp_valid(resp_valid), .resp(resp),
        .tie(tie), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    puf_cro_ctrl #(.SETTLE_CYC(S), .WINDOW(WS), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .challenge(challenge),
        .busy(busy_s), .cro_challenge(cro_challenge_s), .cro_en(cro_en_s),
        .ro_a(ro_a), .ro_b(ro_b), .resp_valid(resp_valid_s), .resp(resp_s),
        .tie(tie_s), .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator generator: changes on falling clk; each rising ro edge is
    // logged with the index of the preceding rising clk edge.
    int pa = 8, pb = 12, ph_a = 0, ph_b = 0;
    int rises_a[$];
    int rises_b[$];
    always @(negedge clk) begin
        ph_a = ph_a + 1;
        if (ph_a >= pa) ph_a = 0;
        ph_b = ph_b + 1;
        if (ph_b >= pb) ph_b = 0;
        ro_a = (ph_a < pa / 2);
        ro_b = (ph_b < pb / 2);
        if (ph_a == 0) rises_a.push_back(cyc - 1);
        if (ph_b == 0) rises_b.push_back(cyc - 1);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int c = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) c++;
        return c;
    endfunction

    // One request on the main instance. b_per2 is the ro_b period used during
    // the second pass only (vote build). poke pulses start while busy.
    task automatic run(input logic [5:0] ch, input int a_per, input int b_per,
                       input int b_per2, input bit same_phase, input bit poke);
        int acc, n_valid, first_en, en_cnt, lo, ea, eb;
        @(negedge clk);
        pa = a_per;
        pb = b_per;
        if (same_phase) ph_b = ph_a;
        rises_a.delete();
        rises_b.delete();
        start = 1'b1;
        challenge = ch;
        acc = cyc;
        n_valid = 0;
        first_en = 0;
        en_cnt = 0;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                chk("challenge_applied", cro_challenge, ch);
                chk("busy_after_accept", busy, 1);
            end
            if (poke && (n == 10 || n == 40)) begin
                start = 1'b1;
                challenge = ~ch;
            end else if (poke && (n == 11 || n == 41)) begin
                start = 1'b0;
                challenge = ch;
            end
            if (cro_en) begin
                en_cnt++;
                if (first_en == 0) first_en = n;
            end
            if (resp_valid) n_valid++;
            if (n == PASS) pb = b_per2;
            if (n == 2 * PASS) pb = b_per;
            if (n == LAT) begin
                chk("resp_valid_latency", resp_valid, 1);
                chk("busy_in_done", busy, 0);
                chk("challenge_held", cro_challenge, ch);
                lo = acc + (NP - 1) * PASS + S;
                ea = count_in(rises_a, lo, lo + W - 1);
                eb = count_in(rises_b, lo, lo + W - 1);
                chk("cnt_a_range", (cnt_a >= ea && cnt_a <= ea + 1), 1);
                chk("cnt_b_range", (cnt_b >= eb && cnt_b <= eb + 1), 1);
                if (a_per == b_per && same_phase) begin
                    chk("tie_equal", tie, 1);
                    chk("resp_equal", resp, 0);
                end else if (ea >= eb + 2) begin
                    chk("resp_a_fast", resp, 1);
                    chk("tie_a_fast", tie, 0);
                end else if (eb >= ea + 2) begin
                    chk("resp_b_fast", resp, 0);
                    chk("tie_b_fast", tie, 0);
                end
            end
        end
        chk("cro_en_first_cycle", first_en, S + 1);
        chk("cro_en_length", en_cnt, NP * W);
        chk("resp_valid_count", n_valid, 1);
        chk("challenge_idle_hold", cro_challenge, ch);
    endtask

    // Long window on the narrow-counter instance: both counters saturate
    task automatic run_sat();
        int acc, n_valid, ea, eb;
        @(negedge clk);
        pa = 8;
        pb = 10;
        rises_a.delete();
        rises_b.delete();
        start_s = 1'b1;
        challenge = 6'(($urandom));
        acc = cyc;
        n_valid = 0;
        for (int n = 1; n <= LATS + 4; n++) begin
            @(negedge clk);
            if (n == 1) start_s = 1'b0;
            if (resp_valid_s) n_valid++;
            if (n == LATS) begin
                ea = count_in(rises_a, acc + (NP - 1) * (S + WS + 4) + S,
                              acc + (NP - 1) * (S + WS + 4) + S + WS - 1);
                eb = count_in(rises_b, acc + (NP - 1) * (S + WS + 4) + S,
                              acc + (NP - 1) * (S + WS + 4) + S + WS - 1);
                chk("sat_valid", resp_valid_s, 1);
                chk("sat_cnt_a", cnt_a_s, (ea > 7) ? 7 : ea);
                chk("sat_cnt_b", cnt_b_s, (eb > 7) ? 7 : eb);
                chk("sat_tie", tie_s, 1);
                chk("sat_resp", resp_s, 0);
            end
        end
        chk("sat_valid_count", n_valid, 1);
    endtask

    // Reset asserted in cycle 30 of a run
    task automatic run_reset();
        int n_valid = 0;
        @(negedge clk);
        pa = 8;
        pb = 12;
        start = 1'b1;
        challenge = 6'h19;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        chk("rst_pre_cro_en", cro_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_cro_en", cro_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_challenge", cro_challenge, 0);
        for (int n = 0; n < LAT + 10; n++) begin
            @(negedge clk);
            if (resp_valid) n_valid++;
        end
        chk("rst_no_valid", n_valid, 0);
    endtask

    initial begin
        int a, b;
        ph_a = $urandom_range(0, 7);
        ph_b = $urandom_range(0, 11);
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_cro_en", cro_en, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp", resp, 0);
        chk("reset_tie", tie, 0);
        chk("reset_challenge", cro_challenge, 0);
        chk("reset_cnt_a", cnt_a, 0);
        chk("reset_cnt_b", cnt_b, 0);
        rst = 1'b0;

        run(6'h2A, 8, 12, 12, 1'b0, 1'b0);
        run(6'h15, 12, 8, 8, 1'b0, 1'b0);
        run(6'h3F, 8, 8, 8, 1'b1, 1'b0);
        run_sat();
        run(6'h07, 8, 12, 12, 1'b0, 1'b1);
        run_reset();
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(6, 20);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(6, 20);
            run(6'($urandom), a, b, b, (a == b), 1'b0);
        end
`ifdef PUF_CRO_CTRL_VOTE_EN
        run(6'h2A, 8, 12, 6, 1'b0, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/puf_cro_ctrl.md
Name: puf_cro_ctrl

Overview:
- Measurement sequencer for a pair of configurable ring-oscillator PUF cells (A and B) that share one 6-bit challenge and one RO enable.
- On request it:
  - latches and applies the challenge,
  - waits for the path to settle,
  - enables both oscillators for a fixed gate window while counting their rising edges,
  - compares the two counts and returns one response bit.
- Sits between the PUF cell pair and the key/ID extraction logic.

Parameters:
- SETTLE_CYC, 4: cycles the challenge is held with cro_en low before the window opens (≥1).
- WINDOW, 64: gate-window length in cycles with cro_en high (≥1).
- CNT_W, 8: width of each edge counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  measurement request; sampled only in IDLE.
- challenge  input  6  challenge word; latched when start is accepted.
- busy  output  1  high from the accepting edge until the return to IDLE.
- cro_challenge  output  6  registered challenge driven to both PUF cells.
- cro_en  output  1  registered RO enable to both PUF cells.
- ro_a  input  1  asynchronous oscillator output A (divided down, below clk/4).
- ro_b  input  1  asynchronous oscillator output B (same constraint).
- resp_valid  output  1  one-cycle pulse; resp, tie, cnt_a and cnt_b are valid.
- resp  output  1  1 when cnt_a > cnt_b, else 0.
- tie  output  1  1 when cnt_a == cnt_b.
- cnt_a  output  CNT_W  final edge count for A; held until next accept.
- cnt_b  output  CNT_W  final edge count for B; held until next accept.

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE;
  - busy, cro_en, resp_valid, resp, tie = 0;
  - cro_challenge = 0; cnt_a, cnt_b = 0;
  - synchronizer flops = 0.
- Synchronizers: ro_a and ro_b each pass through a 2-flop synchronizer plus a third flop for edge detection. A rising edge is counted when sync = 1 and prev = 0.
- States, counting sampled clock edges from the edge that accepts start (edge 0):
  - IDLE: start = 1 → latch challenge into cro_challenge, clear both counters, set busy, go to SETTLE. start while busy is ignored and not queued.
  - SETTLE: occupies SETTLE_CYC cycles (cycles 1..S) with cro_en = 0, then MEASURE.
  - MEASURE: cro_en = 1 for exactly WINDOW cycles (S+1..S+W). Counters increment on detected edges.
  - DRAIN: 3 cycles with cro_en = 0. Counting continues so edges still in the synchronizer pipeline are captured.
  - COMPARE: 1 cycle; computes resp and tie.
  - DONE: 1 cycle; resp_valid = 1, busy = 0. Next state IDLE.
- Latency: resp_valid is high in cycle S+W+5 after the accepting edge. start may be re-accepted on the cycle after DONE.
- Counters saturate at 2^CNT_W−1 and never wrap. If both saturate, tie = 1 and resp = 0.
- Comparison: resp = (cnt_a > cnt_b), unsigned. On a tie, resp = 0.
- cro_challenge is held stable from accept until the next accept, including across IDLE.
- Reset mid-operation: on the next edge everything returns to reset values. cro_en drops in that same cycle. No resp_valid is produced.
- Counters do not change outside MEASURE/DRAIN. Edges on ro_a or ro_b in IDLE, SETTLE, COMPARE or DONE are ignored.

Optional Feature:
- Macro: PUF_CRO_CTRL_VOTE_EN.
- When defined:
  - each accepted start runs three complete SETTLE→MEASURE→DRAIN→COMPARE passes with the same challenge;
  - per-pass resp bits are stored, and the DONE output resp is their majority;
  - tie = 1 only if any pass tied; cnt_a and cnt_b report the third pass;
  - latency becomes 3·(S+W+4)+1 cycles;
  - busy stays high across all passes.
- When undefined: single pass as above. The vote logic is absent.

Test Plan:
- Use S=4, W=64, CNT_W=8.
  - ro_a period 8 clk, ro_b period 12 clk, start with challenge=6'h2A → cro_challenge=6'h2A; cro_en high exactly 64 cycles starting cycle 5; resp_valid in cycle 73; cnt_a=8±1, cnt_b=5±1; resp=1, tie=0.
  - Swap frequencies (ro_a period 12, ro_b period 8) → resp=0, tie=0.
  - Identical 8-clk clocks on both inputs → cnt_a=cnt_b, tie=1, resp=0.
- CNT_W=3, W=256, ro_a period 8 → cnt_a saturates at 7, no wrap; both saturated → tie=1.
- Pulse start in cycles 10 and 40 while busy → ignored; exactly one resp_valid. Assert rst in cycle 30 of a run → next cycle cro_en=0, busy=0, no resp_valid.
- With PUF_CRO_CTRL_VOTE_EN, ro_b forced faster in pass 2 only → passes give 1,0,1; resp=1; resp_valid in cycle 217.
